// File: rtl/tl_timed_cntr.sv
// rtl/tl_timed_cntr.sv - two-road traffic light controller with pedestrian walk and night flash
module tl_timed_cntr #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int WALK_T    = 3,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    input  logic       night,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk
);

    localparam logic [2:0] S_AG    = 3'd0;
    localparam logic [2:0] S_AY    = 3'd1;
    localparam logic [2:0] S_BG    = 3'd2;
    localparam logic [2:0] S_BY    = 3'd3;
    localparam logic [2:0] S_WALK  = 3'd4;
    localparam logic [2:0] S_FLASH = 3'd5;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;
    localparam logic [1:0] L_DARK   = 2'b11;

    // Exit values of the timer: a phase of N cycles exits when tmr reaches N-1.
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_W    = CNT_W'(WALK_T - 1);

    logic [2:0]       state;
    logic [2:0]       nxt_state;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_lim;
    logic             ped_pend;
    logic             nxt_b;
    logic             phase;
    logic             state_chg;
    logic             flash_tick;

    assign state_chg  = (nxt_state != state);
    assign flash_tick = (state == S_FLASH) && (tmr == T_Y);

    // Next-state selection and the saturation value of the timer for the current phase.
    always_comb begin
        nxt_state = state;
        tmr_lim   = T_GMAX;
        case (state)
            S_AG: begin
                tmr_lim = T_GMAX;
                if (((tmr >= T_GMIN) && !Ta) || ((tmr == T_GMAX) && Tb))
                    nxt_state = S_AY;
            end
            S_BG: begin
                tmr_lim = T_GMAX;
                if (((tmr >= T_GMIN) && !Tb) || ((tmr == T_GMAX) && Ta))
                    nxt_state = S_BY;
            end
            S_AY: begin
                tmr_lim = T_Y;
                if (tmr == T_Y) begin
                    if (night)         nxt_state = S_FLASH;
                    else if (ped_pend) nxt_state = S_WALK;
                    else               nxt_state = S_BG;
                end
            end
            S_BY: begin
                tmr_lim = T_Y;
                if (tmr == T_Y) begin
                    if (night)         nxt_state = S_FLASH;
                    else if (ped_pend) nxt_state = S_WALK;
                    else               nxt_state = S_AG;
                end
            end
            S_WALK: begin
                tmr_lim = T_W;
                if (tmr == T_W)
                    nxt_state = nxt_b ? S_BG : S_AG;
            end
            S_FLASH: begin
                tmr_lim = T_Y;
                if (!night)
                    nxt_state = S_AG;
            end
            default: begin
                nxt_state = S_AG;
            end
        endcase
    end

    // State register and phase timer; the flash timer wraps to mark each half-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_AG;
            tmr   <= '0;
        end else begin
            state <= nxt_state;
            if (state_chg || flash_tick)
                tmr <= '0;
            else if (tmr != tmr_lim)
                tmr <= tmr + 1'b1;
        end
    end

    // Pedestrian latch (a new request beats the clear on WALK entry) and post-walk green selector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend <= 1'b0;
            nxt_b    <= 1'b0;
        end else begin
            ped_pend <= ped_req | (ped_pend & ~(state_chg && (nxt_state == S_WALK)));
            if (state_chg && (state == S_AY))
                nxt_b <= 1'b1;
            else if (state_chg && (state == S_BY))
                nxt_b <= 1'b0;
        end
    end

    // Flash phase starts lit on entry and toggles every half-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            phase <= 1'b1;
        else if (state_chg && (nxt_state == S_FLASH))
            phase <= 1'b1;
        else if (flash_tick)
            phase <= ~phase;
    end

    // Lamp decode from registered state only.
    always_comb begin
        La   = L_GREEN;
        Lb   = L_RED;
        walk = 1'b0;
        case (state)
            S_AG:    begin La = L_GREEN;  Lb = L_RED;    end
            S_AY:    begin La = L_YELLOW; Lb = L_RED;    end
            S_BG:    begin La = L_RED;    Lb = L_GREEN;  end
            S_BY:    begin La = L_RED;    Lb = L_YELLOW; end
            S_WALK:  begin La = L_RED;    Lb = L_RED;    walk = 1'b1; end
            S_FLASH: begin
                La = phase ? L_YELLOW : L_DARK;
                Lb = phase ? L_YELLOW : L_DARK;
            end
            default: begin La = L_GREEN;  Lb = L_RED;    end
        endcase
    end

endmodule
